// File: rtl/zone_peak_streamer_pkg.sv
// Shared types, default geometry and pixel/light helper functions for the zone peak streamer.
package zone_pkg;

  localparam int H_ACT_DEF   = 640;
  localparam int V_ACT_DEF   = 480;
  localparam int ZONES_X_DEF = 16;
  localparam int ZONES_Y_DEF = 8;
  localparam int OUT_GAP_DEF = 4;
  localparam logic [15:0] MIN_LIGHT_DEF = 16'd64;

  localparam int ZONE_W_DEF  = H_ACT_DEF / ZONES_X_DEF;
  localparam int ZONE_H_DEF  = V_ACT_DEF / ZONES_Y_DEF;
  localparam int N_ZONES_DEF = ZONES_X_DEF * ZONES_Y_DEF;

  // Zone index width matches the driver's light_index port (up to 512 zones).
  localparam int IDX_W = 9;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DUMP  = 1'b1
  } zone_state_e;

  function automatic logic [7:0] luma_of(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b);
    logic [7:0] m;
    m = (r > g) ? r : g;
    m = (b > m) ? b : m;
    return m;
  endfunction

  // Gamma 2.0 is an exact 8x8 square; the floor keeps dark zones faintly lit.
  function automatic logic [15:0] gamma_floor(input logic [7:0] peak,
                                              input logic [15:0] floor_lvl);
    logic [15:0] sq;
    sq = {8'd0, peak} * {8'd0, peak};
    return (sq > floor_lvl) ? sq : floor_lvl;
  endfunction

endpackage

// File: rtl/zone_peak_streamer_if.sv
// Pixel stream in, zone light triplets out; master drives video, slave is the streamer.
interface zone_peak_streamer_if;
  import zone_pkg::*;

  logic             vs;
  logic             de;
  logic [7:0]       r;
  logic [7:0]       g;
  logic [7:0]       b;
  logic [15:0]      mapped_light;
  logic [IDX_W-1:0] light_index;
  logic             light_refresh;
  logic             busy;
  logic             overrun;

  modport master (
    output vs, de, r, g, b,
    input  mapped_light, light_index, light_refresh, busy, overrun
  );

  modport slave (
    input  vs, de, r, g, b,
    output mapped_light, light_index, light_refresh, busy, overrun
  );

endinterface

// File: rtl/zone_peak_streamer_pos.sv
// Divider-free position tracker: pixel/line counters within a zone plus zone column/row,
// with a frame_end pulse on the falling edge of the last active line.
module zone_pos_counter #(
  parameter int H_ACT   = 640,
  parameter int V_ACT   = 480,
  parameter int ZONES_X = 16,
  parameter int ZONES_Y = 8,
  localparam int ZONE_W = H_ACT / ZONES_X,
  localparam int ZONE_H = V_ACT / ZONES_Y,
  localparam int PXW    = $clog2(ZONE_W + 1),
  localparam int LNW    = $clog2(ZONE_H + 1),
  localparam int ZXW    = $clog2(ZONES_X + 1),
  localparam int ZYW    = $clog2(ZONES_Y + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           vs,
  input  logic           de,
  output logic [ZXW-1:0] zx,
  output logic [ZYW-1:0] zy,
  output logic           pix_valid,
  output logic           frame_end
);

  logic [PXW-1:0] px_r, px_c, px_n;
  logic [ZXW-1:0] zx_r, zx_c, zx_n;
  logic [LNW-1:0] ln_r, ln_c, ln_n;
  logic [ZYW-1:0] zy_r, zy_c, zy_n;
  logic           xo_r, xo_c, xo_n;
  logic           done_r, done_c, done_n;
  logic           de_d_r, de_d_c;
  logic           fall_s;
  logic           last_line_s;

  // A frame-start pulse zeroes the position before the same-cycle pixel is placed.
  always_comb begin
    px_c   = vs ? {PXW{1'b0}} : px_r;
    zx_c   = vs ? {ZXW{1'b0}} : zx_r;
    ln_c   = vs ? {LNW{1'b0}} : ln_r;
    zy_c   = vs ? {ZYW{1'b0}} : zy_r;
    xo_c   = vs ? 1'b0 : xo_r;
    done_c = vs ? 1'b0 : done_r;
    de_d_c = vs ? 1'b0 : de_d_r;
  end

  assign fall_s      = de_d_c & ~de;
  assign last_line_s = (zy_c == ZYW'(ZONES_Y - 1)) && (ln_c == LNW'(ZONE_H - 1));
  assign pix_valid   = de & ~xo_c & ~done_c;
  assign frame_end   = fall_s & ~done_c & last_line_s;
  assign zx          = zx_c;
  assign zy          = zy_c;

  // Advance horizontally on each pixel, vertically on each line end.
  always_comb begin
    px_n   = px_c;
    zx_n   = zx_c;
    xo_n   = xo_c;
    ln_n   = ln_c;
    zy_n   = zy_c;
    done_n = done_c;
    if (de) begin
      if (!xo_c) begin
        if (px_c == PXW'(ZONE_W - 1)) begin
          px_n = {PXW{1'b0}};
          if (zx_c == ZXW'(ZONES_X - 1)) begin
            xo_n = 1'b1;
          end else begin
            zx_n = zx_c + ZXW'(1'b1);
          end
        end else begin
          px_n = px_c + PXW'(1'b1);
        end
      end else begin
        px_n = px_c;
      end
    end else if (fall_s) begin
      px_n = {PXW{1'b0}};
      zx_n = {ZXW{1'b0}};
      xo_n = 1'b0;
      if (!done_c) begin
        if (ln_c == LNW'(ZONE_H - 1)) begin
          ln_n = {LNW{1'b0}};
          if (zy_c == ZYW'(ZONES_Y - 1)) begin
            done_n = 1'b1;
          end else begin
            zy_n = zy_c + ZYW'(1'b1);
          end
        end else begin
          ln_n = ln_c + LNW'(1'b1);
        end
      end else begin
        ln_n = ln_c;
      end
    end else begin
      px_n = px_c;
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      px_r   <= {PXW{1'b0}};
      zx_r   <= {ZXW{1'b0}};
      ln_r   <= {LNW{1'b0}};
      zy_r   <= {ZYW{1'b0}};
      xo_r   <= 1'b0;
      done_r <= 1'b0;
      de_d_r <= 1'b0;
    end else begin
      px_r   <= px_n;
      zx_r   <= zx_n;
      ln_r   <= ln_n;
      zy_r   <= zy_n;
      xo_r   <= xo_n;
      done_r <= done_n;
      de_d_r <= de;
    end
  end

endmodule

// File: rtl/zone_peak_streamer.sv
// Per-zone peak brightness tracker; once per frame streams gamma-mapped zone levels
// to the MiniLED driver as (light, index, refresh) triplets.
module zone_peak_streamer
  import zone_pkg::*;
#(
  parameter int          H_ACT     = H_ACT_DEF,
  parameter int          V_ACT     = V_ACT_DEF,
  parameter int          ZONES_X   = ZONES_X_DEF,
  parameter int          ZONES_Y   = ZONES_Y_DEF,
  parameter int          OUT_GAP   = OUT_GAP_DEF,
  parameter logic [15:0] MIN_LIGHT = MIN_LIGHT_DEF
) (
  input logic                 I_clk,
  input logic                 I_rst,
  zone_peak_streamer_if.slave pix
);

  localparam int N_ZONES = ZONES_X * ZONES_Y;
  localparam int AW      = $clog2(N_ZONES);
  localparam int ZXW     = $clog2(ZONES_X + 1);
  localparam int ZYW     = $clog2(ZONES_Y + 1);
  localparam int GW      = (OUT_GAP > 1) ? $clog2(OUT_GAP) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_ZONES - 1);
  localparam logic [GW-1:0]    GAP_RELOAD = GW'(OUT_GAP - 1);

  zone_state_e      state_r, state_n;
  logic [ZXW-1:0]   zx_s;
  logic [ZYW-1:0]   zy_s;
  logic             pix_valid_s;
  logic             frame_end_s;
  logic             accept_s;
  logic             fire_s;
  logic [7:0]       luma_s;
  logic [IDX_W-1:0] pix_idx_s;
  logic [7:0]       peak_r [N_ZONES];
  logic [IDX_W-1:0] idx_r;
  logic [GW-1:0]    gap_r;
  logic [15:0]      light_r;
  logic [IDX_W-1:0] index_r;
  logic             refresh_r;
  logic             busy_r;
  logic             overrun_r;

  zone_pos_counter #(
    .H_ACT   (H_ACT),
    .V_ACT   (V_ACT),
    .ZONES_X (ZONES_X),
    .ZONES_Y (ZONES_Y)
  ) u_pos (
    .clk       (I_clk),
    .rst       (I_rst),
    .vs        (pix.vs),
    .de        (pix.de),
    .zx        (zx_s),
    .zy        (zy_s),
    .pix_valid (pix_valid_s),
    .frame_end (frame_end_s)
  );

  assign luma_s    = luma_of(pix.r, pix.g, pix.b);
  assign pix_idx_s = IDX_W'(zy_s) * IDX_W'(ZONES_X) + IDX_W'(zx_s);
  // A frame start during a dump re-enters accumulation in the same cycle, so its pixel counts.
  assign accept_s  = pix_valid_s && ((state_r == ACCUM) || pix.vs);

  // Next-state and strobe decision.
  always_comb begin
    state_n = state_r;
    fire_s  = 1'b0;
    case (state_r)
      ACCUM: begin
        if (frame_end_s) begin
          state_n = DUMP;
        end else begin
          state_n = ACCUM;
        end
      end
      DUMP: begin
        if (pix.vs) begin
          state_n = ACCUM;
        end else if (gap_r == {GW{1'b0}}) begin
          fire_s = 1'b1;
          if (idx_r == LAST_IDX) begin
            state_n = ACCUM;
          end else begin
            state_n = DUMP;
          end
        end else begin
          state_n = DUMP;
        end
      end
      default: begin
        state_n = ACCUM;
      end
    endcase
  end

  // State register.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_n;
    end
  end

  // Dump walker: gap countdown starts at zero so the first strobe follows the entry cycle.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      gap_r <= {GW{1'b0}};
      idx_r <= {IDX_W{1'b0}};
    end else if (fire_s) begin
      gap_r <= GAP_RELOAD;
      idx_r <= idx_r + IDX_W'(1'b1);
    end else if ((state_r == DUMP) && !pix.vs) begin
      gap_r <= gap_r - GW'(1'b1);
      idx_r <= idx_r;
    end else begin
      gap_r <= {GW{1'b0}};
      idx_r <= {IDX_W{1'b0}};
    end
  end

  // Peak array: frame start clears every zone, then the same-cycle pixel is folded in.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      for (int i = 0; i < N_ZONES; i++) begin
        peak_r[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < N_ZONES; i++) begin
        if (accept_s && (pix_idx_s == IDX_W'(i))) begin
          peak_r[i] <= (pix.vs || (luma_s > peak_r[i])) ? luma_s : peak_r[i];
        end else if (pix.vs) begin
          peak_r[i] <= 8'd0;
        end else begin
          peak_r[i] <= peak_r[i];
        end
      end
    end
  end

  // Output triplet, busy and sticky overrun.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      light_r   <= 16'd0;
      index_r   <= {IDX_W{1'b0}};
      refresh_r <= 1'b0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      refresh_r <= fire_s;
      busy_r    <= (state_n == DUMP);
      overrun_r <= overrun_r | ((state_r == DUMP) & pix.vs);
      if (fire_s) begin
        light_r <= gamma_floor(peak_r[idx_r[AW-1:0]], MIN_LIGHT);
        index_r <= idx_r;
      end else begin
        light_r <= light_r;
        index_r <= index_r;
      end
    end
  end

  assign pix.mapped_light  = light_r;
  assign pix.light_index   = index_r;
  assign pix.light_refresh = refresh_r;
  assign pix.busy          = busy_r;
  assign pix.overrun       = overrun_r;

endmodule

// File: tb/tb_zone_peak_streamer.sv
// Randomized frame stimulus against a zone-peak model with cycle-exact strobe expectations.
module tb_zone_peak_streamer;
  import zone_pkg::*;

  localparam int H   = 64;
  localparam int V   = 64;
  localparam int ZX  = 16;
  localparam int ZY  = 8;
  localparam int GAP = 4;
  localparam int ZW  = H / ZX;
  localparam int ZH  = V / ZY;
  localparam int N   = ZX * ZY;

  logic clk = 1'b0;
  logic rst;
  always #20 clk = ~clk;

  zone_peak_streamer_if bus ();

  zone_peak_streamer #(
    .H_ACT(H), .V_ACT(V), .ZONES_X(ZX), .ZONES_Y(ZY), .OUT_GAP(GAP), .MIN_LIGHT(16'd64)
  ) dut (
    .I_clk (clk),
    .I_rst (rst),
    .pix   (bus)
  );

  typedef struct {
    int idx;
    int light;
    int at;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   mpeak[N];
  int   got[N];
  int   nstrobe = 0;
  int   errors = 0;
  int   checks = 0;
  int   dump_lo = 0, dump_hi = 0, ov_lo = 0, ov_hi = 0;
  bit   chk_en = 1'b0;
  int   pval, sx, sy;
  logic [7:0] sr, sg, sb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Compare DUT outputs with the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      if (bus.light_refresh === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("strobe_index", 32'(bus.light_index), e.idx);
          check("strobe_light", 32'(bus.mapped_light), e.light);
          check("strobe_cycle", cyc, e.at);
          if (bus.light_index < N) got[bus.light_index] = int'(bus.mapped_light);
          nstrobe++;
        end
      end else if (q.size() > 0 && q[0].at < cyc) begin
        e = q.pop_front();
        check("missed_strobe", cyc, e.at);
      end
      check("busy", 32'(bus.busy), 32'(cyc >= dump_lo && cyc < dump_hi));
      check("overrun", 32'(bus.overrun), 32'(cyc >= ov_lo && cyc < ov_hi));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) mpeak[i] = 0;
  endtask

  task automatic push_dump(input int fe);
    exp_t x;
    for (int i = 0; i < N; i++) begin
      x.idx   = i;
      x.light = (mpeak[i] * mpeak[i] < 64) ? 64 : mpeak[i] * mpeak[i];
      x.at    = fe + 2 + GAP * i;
      q.push_back(x);
    end
    dump_lo = fe + 1;
    dump_hi = fe + 2 + GAP * (N - 1);
  endtask

  task automatic gen_pix(input int mode, input int x, input int y,
                         output logic [7:0] r, output logic [7:0] g, output logic [7:0] b);
    if (mode == 0) begin
      g = 8'(pval);
      r = 8'($urandom_range(pval, 0));
      b = 8'($urandom_range(pval, 0));
    end else if (mode == 1) begin
      r = (x == sx && y == sy) ? sr : 8'd0;
      g = (x == sx && y == sy) ? sg : 8'd0;
      b = (x == sx && y == sy) ? sb : 8'd0;
    end else begin
      r = 8'($urandom_range(255, 0));
      g = 8'($urandom_range(255, 0));
      b = 8'($urandom_range(255, 0));
    end
  endtask

  task automatic drive_frame(input int mode, input bit with_vs, input bit vs_on_pix, input int lines);
    logic [7:0] r, g, b;
    int lum, z;
    for (int i = 0; i < N; i++) got[i] = -1;
    nstrobe = 0;
    if (with_vs && !vs_on_pix) begin
      bus.vs = 1'b1;
      bus.de = 1'b0;
      model_clear();
      tick();
      bus.vs = 1'b0;
      repeat ($urandom_range(2, 1)) tick();
    end
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < H; x++) begin
        gen_pix(mode, x, y, r, g, b);
        bus.r  = r;
        bus.g  = g;
        bus.b  = b;
        bus.de = 1'b1;
        bus.vs = (with_vs && vs_on_pix && x == 0 && y == 0);
        if (bus.vs) model_clear();
        lum = (r > g) ? r : g;
        lum = (b > lum) ? b : lum;
        z = (y / ZH) * ZX + (x / ZW);
        if (lum > mpeak[z]) mpeak[z] = lum;
        tick();
      end
      bus.vs = 1'b0;
      bus.de = 1'b0;
      if (y == V - 1) push_dump(cyc);
      repeat ($urandom_range(3, 1)) tick();
    end
    bus.vs = 1'b0;
  endtask

  task automatic wait_dump();
    int n;
    n = 0;
    while ((q.size() > 0 || cyc <= dump_hi) && n < 3000) begin
      tick();
      n++;
    end
    check("dump_completes", 32'(n < 3000), 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.vs = 1'b0;
    bus.de = 1'b0;
    bus.r = 8'd0;
    bus.g = 8'd0;
    bus.b = 8'd0;
    model_clear();
    repeat (3) tick();
    check("reset_refresh", 32'(bus.light_refresh), 32'd0);
    check("reset_light", 32'(bus.mapped_light), 32'd0);
    check("reset_index", 32'(bus.light_index), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_overrun", 32'(bus.overrun), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // Uniform full-brightness frame.
    pval = 255;
    drive_frame(0, 1'b1, 1'b0, V);
    wait_dump();
    check("white_count", nstrobe, 128);
    check("white_idx0", got[0], 65025);
    check("white_idx127", got[127], 65025);

    // Black frame with one peak-10 pixel at zone (7,2).
    sx = 30; sy = 20; sr = 8'd10; sg = 8'd3; sb = 8'd0;
    drive_frame(1, 1'b1, 1'b0, V);
    wait_dump();
    check("peak10_idx39", got[39], 100);
    check("black_idx0", got[0], 64);
    check("black_idx127", got[127], 64);

    // Single green pixel in zone (1,1).
    sx = 5; sy = 9; sr = 8'd0; sg = 8'd200; sb = 8'd3;
    drive_frame(1, 1'b1, 1'b0, V);
    wait_dump();
    check("single_idx17", got[17], 40000);
    check("single_idx16", got[16], 64);
    check("single_idx18", got[18], 64);

    // Random frame with vs on the first pixel, aborted by vs at the 10th strobe.
    drive_frame(2, 1'b1, 1'b1, V);
    n = 0;
    while (nstrobe < 10 && n < 500) begin
      tick();
      n++;
    end
    check("reach_10th_strobe", nstrobe, 10);
    bus.vs = 1'b1;
    q.delete();
    dump_hi = cyc + 1;
    ov_lo = cyc + 1;
    ov_hi = 32'h3fff_ffff;
    model_clear();
    tick();
    bus.vs = 1'b0;
    repeat (20) tick();
    check("abort_strobe_count", nstrobe, 10);
    check("abort_overrun", 32'(bus.overrun), 32'd1);

    // Partial frame discarded by a restart, then a full random frame.
    drive_frame(2, 1'b1, 1'b0, 20);
    drive_frame(2, 1'b1, 1'b1, V);
    wait_dump();
    check("after_abort_count", nstrobe, 128);

    // Reset mid-accumulation, then a frame without vs at luma 128.
    pval = 255;
    drive_frame(0, 1'b1, 1'b0, 10);
    rst = 1'b1;
    model_clear();
    ov_hi = cyc + 1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    pval = 128;
    drive_frame(0, 1'b0, 1'b0, V);
    wait_dump();
    check("mid128_idx0", got[0], 16384);
    check("mid128_idx77", got[77], 16384);
    check("mid_reset_overrun", 32'(bus.overrun), 32'd0);

    // Consecutive frames: bright then nearly black.
    pval = 255;
    drive_frame(0, 1'b1, 1'b0, V);
    wait_dump();
    pval = 1;
    drive_frame(0, 1'b1, 1'b0, V);
    wait_dump();
    check("dim_idx5", got[5], 64);
    check("dim_idx127", got[127], 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
